// File: rtl/cl_pkg.sv
// Shared Camera Link definitions: transmitter FSM states and CL_data bit positions.
// Used by both the frame transmitter and the receive side.
package cl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_FV_TAIL,
        ST_VBLANK
    } cl_state_e;

    localparam int CL_DVAL_BIT = 26;
    localparam int CL_FVAL_BIT = 25;
    localparam int CL_LVAL_BIT = 24;
    localparam int CL_PIX_W    = 24;
    localparam int CL_WORD_W   = 28;

    function automatic int cl_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cl_tx_timing.sv
// Frame timing core: FSM plus pixel, line and blanking counters.
// Emits combinational framing qualifiers that the top level registers.
module cl_tx_timing
    import cl_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 1024,
    parameter int LINES_PER_FRAME = 768,
    parameter int HBLANK          = 8,
    parameter int VBLANK          = 16,
    parameter int FV_LV_DELAY     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic continuous,
    input  logic pix_valid,
    output logic s_ready,
    output logic lval_en,
    output logic fval,
    output logic frame_done,
    output logic busy,
    output logic frame_lead
);

    localparam int PIX_W  = $clog2(PIXELS_PER_LINE + 1);
    localparam int LINE_W = $clog2(LINES_PER_FRAME + 1);
    localparam int BLK_W  = $clog2(cl_max3(HBLANK, VBLANK, FV_LV_DELAY) + 1);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [BLK_W-1:0]  LEAD_LAST = BLK_W'(FV_LV_DELAY - 1);
    localparam logic [BLK_W-1:0]  HB_LAST   = BLK_W'(HBLANK - 1);
    localparam logic [BLK_W-1:0]  VB_LAST   = BLK_W'(VBLANK - 1);

    cl_state_e         state_q, state_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              accept;

    assign s_ready    = (state_q == ST_LINE);
    assign accept     = s_ready & pix_valid;
    // A line is "open" once its first beat has gone out; LVAL then stays high through stalls.
    assign lval_en    = (state_q == ST_LINE) && (pix_cnt_q != '0);
    assign fval       = (state_q inside {ST_FV_LEAD, ST_LINE, ST_HBLANK, ST_FV_TAIL});
    assign frame_done = (state_q == ST_VBLANK) && (blk_cnt_q == '0);
    assign busy       = (state_q != ST_IDLE);
    assign frame_lead = (state_q == ST_FV_LEAD);

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FV_LEAD;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    blk_cnt_d  = '0;
                end
            end
            ST_FV_LEAD: begin
                if (blk_cnt_q == LEAD_LAST) begin
                    state_d   = ST_LINE;
                    blk_cnt_d = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            ST_LINE: begin
                if (accept) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        blk_cnt_d = '0;
                        if (line_cnt_q == LINE_LAST) begin
                            state_d = ST_FV_TAIL;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                            state_d    = ST_HBLANK;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_HBLANK: begin
                if (blk_cnt_q == HB_LAST) begin
                    state_d   = ST_LINE;
                    blk_cnt_d = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            ST_FV_TAIL: begin
                state_d   = ST_VBLANK;
                blk_cnt_d = '0;
            end
            ST_VBLANK: begin
                if (blk_cnt_q == VB_LAST) begin
                    blk_cnt_d = '0;
                    if (continuous) begin
                        state_d    = ST_FV_LEAD;
                        pix_cnt_d  = '0;
                        line_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

endmodule

// File: rtl/cl_frame_transmit.sv
// Camera Link base-configuration frame transmitter: registered 28-bit CL_data word.
// Define CL_TX_TEST_PATTERN_EN to build the per-frame counting test pattern behind test_mode.
module cl_frame_transmit
    import cl_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 1024,
    parameter int LINES_PER_FRAME = 768,
    parameter int HBLANK          = 8,
    parameter int VBLANK          = 16,
    parameter int FV_LV_DELAY     = 2
) (
    input  logic        CL_clk,
    input  logic        CL_rst,
    input  logic        start,
    input  logic        continuous,
    input  logic        test_mode,
    input  logic [23:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [27:0] CL_data,
    output logic        busy,
    output logic        frame_done
);

    logic                 pix_valid;
    logic [CL_PIX_W-1:0]  pix_data;
    logic                 accept;
    logic                 lval_en;
    logic                 fval;
    logic                 done_t;
    logic                 busy_t;
    logic                 frame_lead;
    logic [CL_WORD_W-1:0] word_q, word_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    cl_tx_timing #(
        .PIXELS_PER_LINE (PIXELS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .HBLANK          (HBLANK),
        .VBLANK          (VBLANK),
        .FV_LV_DELAY     (FV_LV_DELAY)
    ) u_timing (
        .clk        (CL_clk),
        .rst        (CL_rst),
        .start      (start),
        .continuous (continuous),
        .pix_valid  (pix_valid),
        .s_ready    (s_ready),
        .lval_en    (lval_en),
        .fval       (fval),
        .frame_done (done_t),
        .busy       (busy_t),
        .frame_lead (frame_lead)
    );

`ifdef CL_TX_TEST_PATTERN_EN
    logic [CL_PIX_W-1:0] pat_cnt_q, pat_cnt_d;

    // The pattern never stalls; the counter is cleared while the frame lead-in runs.
    assign pix_valid = test_mode | s_valid;
    assign pix_data  = test_mode ? pat_cnt_q : s_data;

    always_comb begin
        pat_cnt_d = pat_cnt_q;
        if (frame_lead) begin
            pat_cnt_d = '0;
        end else if (accept) begin
            pat_cnt_d = pat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CL_clk or posedge CL_rst) begin
        if (CL_rst) begin
            pat_cnt_q <= '0;
        end else begin
            pat_cnt_q <= pat_cnt_d;
        end
    end
`else
    logic unused_sigs;
    assign unused_sigs = test_mode | frame_lead;
    assign pix_valid   = s_valid;
    assign pix_data    = s_data;
`endif

    assign accept = s_ready & pix_valid;

    always_comb begin
        word_d              = '0;
        word_d[CL_FVAL_BIT] = fval;
        word_d[CL_LVAL_BIT] = lval_en | accept;
        word_d[CL_DVAL_BIT] = accept;
        if (accept) begin
            word_d[CL_PIX_W-1:0] = pix_data;
        end else if (lval_en) begin
            word_d[CL_PIX_W-1:0] = word_q[CL_PIX_W-1:0];
        end
        busy_d = busy_t;
        done_d = done_t;
    end

    always_ff @(posedge CL_clk or posedge CL_rst) begin
        if (CL_rst) begin
            word_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign CL_data    = word_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_cl_frame_transmit.sv
// Self-checking bench for cl_frame_transmit: a frame-layout reference model builds the
// expected CL_data / busy / frame_done / s_ready per clock edge from the input patterns.
module tb_cl_frame_transmit;

    localparam int PPL  = 4;
    localparam int LPF  = 2;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int LEAD = 2;
    localparam int MAXE = 1024;

    localparam logic [27:0] W_IDLE = 28'h0000000;
    localparam logic [27:0] W_FV   = 28'h2000000;

    logic        clk;
    logic        CL_rst;
    logic        start;
    logic        continuous;
    logic        test_mode;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [27:0] CL_data;
    logic        busy;
    logic        frame_done;

    logic        spat [MAXE];
    logic        vpat [MAXE];
    logic        cpat [MAXE];
    logic [23:0] dpat [MAXE];

    logic [27:0] xw  [MAXE];
    logic        xb  [MAXE];
    logic        xfd [MAXE];
    logic        xr  [MAXE];

    logic [27:0] ow  [MAXE];
    logic        ob  [MAXE];
    logic        ofd [MAXE];

    bit pat_mode;
    int total;
    int bad;

    cl_frame_transmit #(
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .HBLANK          (HB),
        .VBLANK          (VB),
        .FV_LV_DELAY     (LEAD)
    ) dut (
        .CL_clk     (clk),
        .CL_rst     (CL_rst),
        .start      (start),
        .continuous (continuous),
        .test_mode  (test_mode),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .CL_data    (CL_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic put(input int e, input logic [27:0] w, input logic b, input logic fd, input logic r);
        if (e < MAXE) begin
            xw[e]  = w;
            xb[e]  = b;
            xfd[e] = fd;
            xr[e]  = r;
        end
    endtask

    // Walks the frame layout: lead-in, lines with HBLANK gaps, tail, VBLANK.
    task automatic model(output int last_e);
        int          e;
        int          beats;
        bit          more;
        logic [23:0] held;
        logic [23:0] pc;
        logic        v;
        logic [23:0] d;
        for (int i = 0; i < MAXE; i++) put(i, W_IDLE, 1'b0, 1'b0, 1'b0);
        e    = 0;
        held = '0;
        pc   = '0;
        more = 1'b0;
        while (e < 80) begin
            if (!spat[e]) begin
                e++;
                continue;
            end
            e++;
            do begin
                pc = '0;
                for (int i = 0; i < LEAD; i++) begin
                    put(e, W_FV, 1'b1, 1'b0, 1'b0);
                    e++;
                end
                for (int l = 0; l < LPF; l++) begin
                    beats = 0;
                    while (beats < PPL) begin
                        v = pat_mode ? 1'b1 : vpat[e];
                        d = pat_mode ? pc : dpat[e];
                        if (v) begin
                            put(e, {4'h7, d}, 1'b1, 1'b0, 1'b1);
                            held = d;
                            beats++;
                            pc = pc + 24'd1;
                        end else if (beats > 0) begin
                            put(e, {4'h3, held}, 1'b1, 1'b0, 1'b1);
                        end else begin
                            put(e, W_FV, 1'b1, 1'b0, 1'b1);
                        end
                        e++;
                    end
                    if (l < LPF - 1) begin
                        for (int i = 0; i < HB; i++) begin
                            put(e, W_FV, 1'b1, 1'b0, 1'b0);
                            e++;
                        end
                    end
                end
                put(e, W_FV, 1'b1, 1'b0, 1'b0);
                e++;
                for (int i = 0; i < VB; i++) begin
                    put(e, W_IDLE, 1'b1, (i == 0), 1'b0);
                    if (i == VB - 1) more = cpat[e];
                    e++;
                end
            end while (more);
        end
        last_e = e;
    endtask

    task automatic clear_pats();
        for (int c = 0; c < MAXE; c++) begin
            spat[c] = 1'b0;
            vpat[c] = 1'b1;
            cpat[c] = 1'b0;
            dpat[c] = '0;
        end
        pat_mode = 1'b0;
    endtask

    // Data 0x10.. per beat for a 16-edge frame starting at edge 0.
    task automatic set_plan_data();
        int rel;
        for (int c = 1; c < MAXE; c++) begin
            rel = (c - 1) % 16 + 1;
            dpat[c] = 24'(rel < 9 ? 16 + rel - 3 : 20 + rel - 9);
        end
    endtask

    task automatic run_check(input string tag);
        int n;
        model(n);
        n = n + 2;
        if (n > MAXE) n = MAXE;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            total++;
            if (s_ready !== xr[c]) begin
                bad++;
                $display("FAIL %s.s_ready edge=%0d got=%0b want=%0b", tag, c, s_ready, xr[c]);
            end
            start      = spat[c];
            s_valid    = vpat[c];
            s_data     = dpat[c];
            continuous = cpat[c];
            @(posedge clk);
            #1;
            ow[c]  = CL_data;
            ob[c]  = busy;
            ofd[c] = frame_done;
            total++;
            if (CL_data !== xw[c]) begin
                bad++;
                $display("FAIL %s.cl_data edge=%0d got=%h want=%h", tag, c, CL_data, xw[c]);
            end
            total++;
            if (busy !== xb[c]) begin
                bad++;
                $display("FAIL %s.busy edge=%0d got=%0b want=%0b", tag, c, busy, xb[c]);
            end
            total++;
            if (frame_done !== xfd[c]) begin
                bad++;
                $display("FAIL %s.frame_done edge=%0d got=%0b want=%0b", tag, c, frame_done, xfd[c]);
            end
        end
        start      = 1'b0;
        continuous = 1'b0;
        s_valid    = 1'b0;
        $display("run %s: edges=%0d total=%0d bad=%0d", tag, n, total, bad);
    endtask

    task automatic test_reset();
        CL_rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (CL_data !== W_IDLE || s_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%h/%0b/%0b/%0b want=0/0/0/0", CL_data, s_ready, busy, frame_done);
        end
        @(negedge clk);
        CL_rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (CL_data !== W_IDLE || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%h/%0b want=0/0", CL_data, busy);
        end
        $display("run reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_single_frame();
        int          ed [7] = '{3, 6, 7, 8, 9, 12, 13};
        logic [27:0] wv [7] = '{28'h7000010, 28'h7000013, 28'h2000000, 28'h2000000,
                                28'h7000014, 28'h7000017, 28'h2000000};
        clear_pats();
        set_plan_data();
        spat[0] = 1'b1;
        run_check("single_frame");
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ow[ed[i]] !== wv[i]) begin
                bad++;
                $display("FAIL single_frame.word edge=%0d got=%h want=%h", ed[i], ow[ed[i]], wv[i]);
            end
        end
        total++;
        if (ofd[14] !== 1'b1 || ofd[15] !== 1'b0 || ow[14] !== W_IDLE) begin
            bad++;
            $display("FAIL single_frame.fval_fall got=%0b/%0b/%h want=1/0/0", ofd[14], ofd[15], ow[14]);
        end
        total++;
        if (ob[16] !== 1'b1 || ob[17] !== 1'b0) begin
            bad++;
            $display("FAIL single_frame.busy_end got=%0b/%0b want=1/0", ob[16], ob[17]);
        end
    endtask

    task automatic test_continuous();
        clear_pats();
        set_plan_data();
        spat[0]  = 1'b1;
        cpat[16] = 1'b1;
        spat[5]  = 1'b1;
        run_check("continuous");
        total++;
        if (ow[17] !== W_FV || ow[19] !== 28'h7000010 || ow[28] !== 28'h7000017) begin
            bad++;
            $display("FAIL continuous.second_frame got=%h/%h/%h want=2000000/7000010/7000017",
                     ow[17], ow[19], ow[28]);
        end
        total++;
        if (ofd[30] !== 1'b1 || ob[33] !== 1'b0) begin
            bad++;
            $display("FAIL continuous.end got=%0b/%0b want=1/0", ofd[30], ob[33]);
        end
    endtask

    task automatic test_stall();
        clear_pats();
        set_plan_data();
        spat[0] = 1'b1;
        vpat[5] = 1'b0;
        vpat[6] = 1'b0;
        vpat[7] = 1'b0;
        run_check("stall");
        for (int c = 5; c <= 7; c++) begin
            total++;
            if (ow[c] !== 28'h3000011) begin
                bad++;
                $display("FAIL stall.hold edge=%0d got=%h want=3000011", c, ow[c]);
            end
        end
        total++;
        if (ow[9][26] !== 1'b1 || ow[10] !== W_FV || ofd[17] !== 1'b1) begin
            bad++;
            $display("FAIL stall.extend got=%h/%h/%0b want=dval/2000000/1", ow[9], ow[10], ofd[17]);
        end
    endtask

    task automatic test_reset_mid();
        clear_pats();
        set_plan_data();
        spat[0] = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            start   = spat[c];
            s_valid = 1'b1;
            s_data  = dpat[c];
            @(posedge clk);
        end
        #1;
        total++;
        if (CL_data !== 28'h7000015) begin
            bad++;
            $display("FAIL reset_mid.pre got=%h want=7000015", CL_data);
        end
        #1;
        CL_rst = 1'b1;
        #1;
        total++;
        if (CL_data !== W_IDLE || s_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid.clear got=%h/%0b/%0b/%0b want=0/0/0/0", CL_data, s_ready, busy, frame_done);
        end
        @(negedge clk);
        CL_rst  = 1'b0;
        s_valid = 1'b0;
        run_check("after_reset");
        total++;
        if (ow[3] !== 28'h7000010 || ow[9] !== 28'h7000014 || ofd[14] !== 1'b1) begin
            bad++;
            $display("FAIL after_reset.fresh got=%h/%h/%0b want=7000010/7000014/1", ow[3], ow[9], ofd[14]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            clear_pats();
`ifndef CL_TX_TEST_PATTERN_EN
            test_mode = 1'($urandom_range(0, 1));
`endif
            for (int c = 0; c < MAXE; c++) begin
                dpat[c] = 24'($urandom());
                if (c < 60) spat[c] = ($urandom_range(0, 15) == 0);
                if (c < 80) cpat[c] = 1'($urandom_range(0, 1));
                if (c < 300) vpat[c] = ($urandom_range(0, 3) != 0);
            end
            spat[$urandom_range(0, 5)] = 1'b1;
            run_check($sformatf("random%0d", it));
        end
        test_mode = 1'b0;
    endtask

`ifdef CL_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        clear_pats();
        for (int c = 0; c < MAXE; c++) vpat[c] = 1'b0;
        set_plan_data();
        pat_mode  = 1'b1;
        test_mode = 1'b1;
        spat[0]   = 1'b1;
        cpat[16]  = 1'b1;
        run_check("pattern");
        total++;
        if (ow[3] !== 28'h7000000 || ow[12] !== 28'h7000007 || ow[19] !== 28'h7000000) begin
            bad++;
            $display("FAIL pattern.count got=%h/%h/%h want=7000000/7000007/7000000", ow[3], ow[12], ow[19]);
        end
        test_mode = 1'b0;
        pat_mode  = 1'b0;
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        CL_rst     = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        test_mode  = 1'b0;
        s_data     = '0;
        s_valid    = 1'b0;
        pat_mode   = 1'b0;
        test_reset();
        test_single_frame();
        test_continuous();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef CL_TX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
